apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_cmd_master.sv | 183 ++++++++++++++++++
 tb/tb_apb_cmd_master.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB command master: buffers read/write commands in a small FIFO and issues them
// as APB transfers to a slave that never stalls, returning read data as a pulse.
module apb_cmd_master #(
    parameter int unsigned Amba_Word       = 24,
    parameter int unsigned Amba_Addr_Depth = 13,
    parameter int unsigned Fifo_Depth      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [Amba_Addr_Depth-1:0] cmd_addr,
    input  logic [Amba_Word-1:0]       cmd_wdata,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [Amba_Addr_Depth-1:0] PADDR,
    output logic [Amba_Word-1:0]       PWDATA,
    input  logic [Amba_Word-1:0]       PRDATA,
    output logic                       rsp_valid,
    output logic [Amba_Word-1:0]       rsp_rdata,
    output logic                       busy,
    output logic [15:0]                xfer_count
);

    localparam int unsigned PtrW  = $clog2(Fifo_Depth);
    localparam int unsigned CntW  = $clog2(Fifo_Depth + 1);
    localparam int unsigned XferW = 16;

    typedef struct packed {
        logic                       write;
        logic [Amba_Addr_Depth-1:0] addr;
        logic [Amba_Word-1:0]       wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e                     state_q, state_d;
    cmd_t                       mem_q [Fifo_Depth];
    cmd_t                       mem_d [Fifo_Depth];
    logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic                       psel_q, psel_d;
    logic                       penable_q, penable_d;
    logic                       pwrite_q, pwrite_d;
    logic [Amba_Addr_Depth-1:0] paddr_q, paddr_d;
    logic [Amba_Word-1:0]       pwdata_q, pwdata_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [Amba_Word-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                       busy_q, busy_d;
    logic [XferW-1:0]           xfer_count_q, xfer_count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    cmd_t head;

    assign full      = (cnt_q == CntW'(Fifo_Depth));
    assign empty     = (cnt_q == CntW'(0));
    // Acceptance is held off during reset so nothing is taken into a flushed FIFO.
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];

    // Next-state: FIFO bookkeeping, APB sequencing, response and counter update.
    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        xfer_count_d = xfer_count_q;
        pop          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                xfer_count_d = xfer_count_q + XferW'(1);
                if (!pwrite_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = PRDATA;
                end
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            pwrite_d = head.write;
            paddr_d  = head.addr;
            if (head.write) begin
                pwdata_d = head.wdata;
            end
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        if (push) begin
            mem_d[wr_ptr_q] = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
        busy_d    = (cnt_d != CntW'(0)) || (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            busy_q       <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            busy_q       <= busy_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    // Storage is only meaningful between the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign busy       = busy_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: cycle-level reference model plus an in-order scoreboard
// of APB transfers and read responses, driven by directed scenarios.
module tb_apb_cmd_master;

    localparam int unsigned AW = 24;
    localparam int unsigned AD = 13;
    localparam int unsigned FD = 4;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AD-1:0] cmd_addr;
    logic [AW-1:0] cmd_wdata;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AD-1:0] PADDR;
    logic [AW-1:0] PWDATA;
    logic [AW-1:0] PRDATA;
    logic          rsp_valid;
    logic [AW-1:0] rsp_rdata;
    logic          busy;
    logic [15:0]   xfer_count;

    apb_cmd_master #(
        .Amba_Word      (AW),
        .Amba_Addr_Depth(AD),
        .Fifo_Depth     (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .xfer_count(xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          w;
        logic [AD-1:0] a;
        logic [AW-1:0] d;
    } tcmd_t;

    int errors = 0;
    int checks = 0;

    // Reference model state (0 idle, 1 setup, 2 access)
    int            m_state = 0;
    tcmd_t         m_fifo[$];
    logic          m_pwrite = 1'b0;
    logic [AD-1:0] m_paddr  = '0;
    logic [AW-1:0] m_pwdata = '0;
    logic          m_rsp_v  = 1'b0;
    logic [AW-1:0] m_rsp_d  = '0;
    logic [15:0]   m_cnt    = '0;

    // Scoreboard of expected transfers and read responses
    tcmd_t         sb_xfer[$];
    logic [AW-1:0] sb_rsp[$];

    bit saw_full = 1'b0;
    int psel_hi  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        tcmd_t cur;
        tcmd_t c;
        bit    acc;
        bit    do_pop;
        if (rst) begin
            m_state  = 0;
            m_fifo.delete();
            sb_xfer.delete();
            sb_rsp.delete();
            m_pwrite = 1'b0;
            m_paddr  = '0;
            m_pwdata = '0;
            m_rsp_v  = 1'b0;
            m_rsp_d  = '0;
            m_cnt    = '0;
        end else begin
            cur    = {cmd_write, cmd_addr, cmd_wdata};
            acc    = cmd_valid && (m_fifo.size() < FD);
            do_pop = (m_state != 1) && (m_fifo.size() > 0);
            m_rsp_v = 1'b0;
            if (m_state == 2) begin
                m_cnt = m_cnt + 16'd1;
                if (!m_pwrite) begin
                    m_rsp_v = 1'b1;
                    m_rsp_d = PRDATA;
                    sb_rsp.push_back(PRDATA);
                end
            end
            if (m_state == 1)  m_state = 2;
            else if (do_pop)   m_state = 1;
            else               m_state = 0;
            if (do_pop) begin
                c        = m_fifo.pop_front();
                m_pwrite = c.w;
                m_paddr  = c.a;
                if (c.w) m_pwdata = c.d;
            end
            if (acc) begin
                m_fifo.push_back(cur);
                sb_xfer.push_back(cur);
            end
        end
    endtask

    task automatic compare_all();
        tcmd_t         e;
        logic [AW-1:0] r;
        chk("cmd_ready", cmd_ready, !rst && (m_fifo.size() < FD));
        chk("psel", PSEL, m_state != 0);
        chk("penable", PENABLE, m_state == 2);
        chk("pwrite", PWRITE, m_pwrite);
        chk("paddr", PADDR, m_paddr);
        chk("pwdata", PWDATA, m_pwdata);
        chk("rsp_valid", rsp_valid, m_rsp_v);
        chk("rsp_rdata", rsp_rdata, m_rsp_d);
        chk("busy", busy, (m_fifo.size() != 0) || (m_state != 0));
        chk("xfer_count", xfer_count, m_cnt);
        if (!cmd_ready && !rst) saw_full = 1'b1;
        if (PSEL === 1'b1) psel_hi++;
        if (PSEL === 1'b1 && PENABLE === 1'b1) begin
            chk("sb_xfer_avail", sb_xfer.size() != 0, 1);
            if (sb_xfer.size() != 0) begin
                e = sb_xfer.pop_front();
                chk("sb_pwrite", PWRITE, e.w);
                chk("sb_paddr", PADDR, e.a);
                if (e.w) chk("sb_pwdata", PWDATA, e.d);
            end
        end
        if (rsp_valid === 1'b1) begin
            chk("sb_rsp_avail", sb_rsp.size() != 0, 1);
            if (sb_rsp.size() != 0) begin
                r = sb_rsp.pop_front();
                chk("sb_rsp_data", rsp_rdata, r);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
        PRDATA = AW'($urandom);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_exit_ready", cmd_ready, 1);
        chk("rst_exit_psel", PSEL, 0);
    endtask

    task automatic push_cmd(input logic w, input logic [AD-1:0] a, input logic [AW-1:0] d);
        bit acc;
        bit done = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int n = 0; n < 40; n++) begin
            acc = cmd_ready;
            tick();
            if (acc) begin
                done = 1'b1;
                break;
            end
        end
        chk("push_accepted", done, 1);
    endtask

    task automatic wait_idle(input int limit, output int cyc);
        cmd_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < limit) begin
            tick();
            cyc++;
        end
        chk("idle_reached", busy, 0);
    endtask

    int cyc;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;

        // Reset state
        tick();
        chk("rst_ready_low", cmd_ready, 0);
        chk("rst_xfer", xfer_count, 0);
        chk("rst_pwdata", PWDATA, 0);
        do_reset();

        // Single write
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 13'h0010; cmd_wdata = 24'h00ABCD;
        chk("wr_c0_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("wr_c2_psel", PSEL, 1);
        chk("wr_c2_penable", PENABLE, 0);
        tick();
        chk("wr_c3_penable", PENABLE, 1);
        chk("wr_c3_paddr", PADDR, 13'h0010);
        chk("wr_c3_pwdata", PWDATA, 24'h00ABCD);
        chk("wr_c3_pwrite", PWRITE, 1);
        tick();
        chk("wr_c4_xfer", xfer_count, 1);
        chk("wr_c4_rsp", rsp_valid, 0);
        chk("wr_c4_psel", PSEL, 0);

        // Single read
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h1FFF; cmd_wdata = 24'h777777;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("rd_c3_penable", PENABLE, 1);
        chk("rd_c3_paddr", PADDR, 13'h1FFF);
        chk("rd_c3_pwdata_hold", PWDATA, 24'h00ABCD);
        PRDATA = 24'h123456;
        tick();
        chk("rd_c4_rsp_valid", rsp_valid, 1);
        chk("rd_c4_rsp_rdata", rsp_rdata, 24'h123456);
        chk("rd_c4_psel", PSEL, 0);
        chk("rd_c4_penable", PENABLE, 0);
        tick();
        chk("rd_c5_rsp_valid", rsp_valid, 0);
        chk("rd_c5_rsp_hold", rsp_rdata, 24'h123456);

        // Back-to-back: six consecutive writes
        do_reset();
        psel_hi = 0;
        for (int i = 0; i < 6; i++) push_cmd(1'b1, AD'(i * 8 + 4), AW'(i * 17 + 1));
        wait_idle(30, cyc);
        chk("b2b_within_14", (6 + cyc) <= 14, 1);
        chk("b2b_psel_cycles", psel_hi, 12);
        chk("b2b_xfer", xfer_count, 6);

        // Sustained pushes until the FIFO fills
        saw_full = 1'b0;
        for (int i = 0; i < 10; i++) push_cmd(i[0], AD'(13'h100 + i), AW'(24'hF00000 + i));
        wait_idle(40, cyc);
        chk("full_seen", saw_full, 1);
        chk("full_xfer", xfer_count, 16);

        // Push and pop in the same cycle at occupancy 2
        do_reset();
        push_cmd(1'b1, 13'h0A1, 24'h0000A1);
        push_cmd(1'b0, 13'h0A2, 24'h0000A2);
        push_cmd(1'b1, 13'h0A3, 24'h0000A3);
        chk("pp_access", PENABLE, 1);
        chk("pp_occ_before", dut.cnt_q, 2);
        push_cmd(1'b1, 13'h0A4, 24'h0000A4);
        chk("pp_occ_after", dut.cnt_q, 2);
        wait_idle(30, cyc);
        chk("pp_xfer", xfer_count, 4);

        // Reset during the ACCESS of a read with two commands queued
        do_reset();
        push_cmd(1'b0, 13'h0B1, 24'h0);
        push_cmd(1'b1, 13'h0B2, 24'h0000B2);
        push_cmd(1'b1, 13'h0B3, 24'h0000B3);
        chk("mr_in_access", PENABLE, 1);
        chk("mr_is_read", PWRITE, 0);
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mr_rsp", rsp_valid, 0);
        chk("mr_xfer", xfer_count, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ready_in_rst", cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("mr_ready_after", cmd_ready, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("mr_idle_busy", busy, 0);

        // Random mix with gaps
        for (int i = 0; i < 16; i++) begin
            push_cmd(1'($urandom), AD'($urandom), AW'($urandom));
            cmd_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle(60, cyc);
        chk("rand_sb_empty", sb_xfer.size() + sb_rsp.size(), 0);

        // Counter wrap
        force dut.xfer_count_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        tick();
        release dut.xfer_count_q;
        push_cmd(1'b1, 13'h0C0, 24'h0000C0);
        wait_idle(20, cyc);
        chk("wrap_xfer", xfer_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
